// File: rtl/alu_arbiter.sv
// Round-robin front-end sharing one combinational ALU between two requesters.
// Optional illegal-opcode screening is enabled by defining ALU_ARB_ILLEGAL_OP_CHECK_EN.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_over,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_c,
    output logic              rsp_over,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              last_gnt;
    logic              gnt0, gnt1, accept;
    logic [DATA_W-1:0] iss_a, iss_b;
    logic [OP_W-1:0]   iss_op;
    logic              iss_id, iss_err;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [OP_W-1:0]   raw_op, sel_op;
    logic              sel_err;

`ifdef ALU_ARB_ILLEGAL_OP_CHECK_EN
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op == OP_W'(32'h00)) || (op == OP_W'(32'h02)) || (op == OP_W'(32'h03)) ||
               ((op >= OP_W'(32'h20)) && (op <= OP_W'(32'h27)));
    endfunction
`endif

    // Requester 0 wins a tie unless it was the last one granted; the rst_n
    // term keeps both readies low while reset is held.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state == IDLE) begin
            if (req0_valid && (!req1_valid || last_gnt))
                gnt0 = 1'b1;
            else if (req1_valid)
                gnt1 = 1'b1;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;

    always_comb begin
        sel_a   = gnt1 ? req1_a  : req0_a;
        sel_b   = gnt1 ? req1_b  : req0_b;
        raw_op  = gnt1 ? req1_op : req0_op;
        sel_op  = raw_op;
        sel_err = 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_CHECK_EN
        // Illegal ops are neutralised at issue so the ALU never sees them.
        if (!op_legal(raw_op)) begin
            sel_err = 1'b1;
            sel_a   = '0;
            sel_b   = '0;
            sel_op  = '0;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept)
                last_gnt <= gnt1;
        end
    end

    // Issue registers: the only source of alu_*, held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_a   <= '0;
            iss_b   <= '0;
            iss_op  <= '0;
            iss_id  <= 1'b0;
            iss_err <= 1'b0;
        end else if (accept) begin
            iss_a   <= sel_a;
            iss_b   <= sel_b;
            iss_op  <= sel_op;
            iss_id  <= gnt1;
            iss_err <= sel_err;
        end
    end

    assign alu_a  = iss_a;
    assign alu_b  = iss_b;
    assign alu_op = iss_op;

    // Response registers load only at the end of EXEC, so they stay frozen in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id   <= 1'b0;
            rsp_c    <= '0;
            rsp_over <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id   <= iss_id;
            rsp_c    <= iss_err ? '0 : alu_c;
            rsp_over <= iss_err ? 1'b0 : alu_over;
            rsp_err  <= iss_err;
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequential front-end that shares the single combinational 32-bit ALU between two independent requesters. Accepts one operation at a time over valid/ready handshakes and arbitrates round-robin between the requesters. Drives the ALU operand and opcode inputs from a registered issue stage, then captures the ALU result and overflow flag. Returns them on a shared, tagged response channel. Sits between the decode/issue logic of two pipelines and the ALU instance.

## Interface
Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- OP_W, 6, opcode width; must match the ALU.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester N presents an operation.
- req0_ready / req1_ready  out  1  requester N's operation is accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands A, B.
- req0_op / req1_op  in  OP_W  ALU opcode.
- alu_a, alu_b  out  DATA_W  to ALU A, B.
- alu_op  out  OP_W  to ALU Op.
- alu_c  in  DATA_W  from ALU C.
- alu_over  in  1  from ALU Over.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that issued the op (0/1).
- rsp_c  out  DATA_W  captured result.
- rsp_over  out  1  captured overflow.
- rsp_err  out  1  illegal opcode (see Configuration).
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states:
  - IDLE: req ready asserted per arbitration; on handshake, latch a/b/op/id into issue regs and go to EXEC.
  - EXEC: issue regs drive alu_*; at the cycle end, capture alu_c/alu_over into response regs and go to RESP.
  - RESP: rsp_valid=1; on rsp_ready, go to IDLE.
- Single transaction in flight. Both req ready signals are 0 in EXEC and RESP.
- Arbitration, IDLE only:
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last time is granted.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - At most one req ready is high per cycle.
  - A ready is high only if the matching valid is high.
- alu_a/alu_b/alu_op are the issue registers, held stable from EXEC until the next accept. No combinational path from req_* to alu_*.
- Response regs (rsp_id, rsp_c, rsp_over, rsp_err) are held constant while rsp_valid=1 and rsp_ready=0.
- A requester deasserting valid before ready is legal. No grant occurs and the pointer is unchanged.
- The pointer updates only on an accepted handshake.

## Timing
- Accept in cycle T → ALU driven in T+1 → rsp_valid first high in T+2. Minimum 3 cycles per op.
- Back-to-back throughput: one op per 3 cycles when rsp_ready is held high. A new accept can occur in the cycle after the RESP handshake.
- Reset values:
  - Outputs: req0_ready=0, req1_ready=0, rsp_valid=0, rsp_id=0, rsp_c=0, rsp_over=0, rsp_err=0, busy=0, alu_a=0, alu_b=0, alu_op=0.
  - Internal: state IDLE, pointer=1.
- Reset mid-operation (EXEC or RESP): the in-flight op is dropped. rsp_valid falls asynchronously with rst_n. No response is produced after release.
- req ready in IDLE is combinational from the req valid signals and the pointer.

## Configuration
- Macro: ALU_ARB_ILLEGAL_OP_CHECK_EN.
- Defined:
  - Legal opcodes are 0x00, 0x02, 0x03, 0x20–0x27.
  - An accepted op outside this set still takes the EXEC/RESP path, but alu_op is driven 0x00 and alu_a/alu_b are driven 0.
  - Response carries rsp_err=1, rsp_c=0, rsp_over=0.
- Undefined: rsp_err is tied 0. Any opcode is passed through to the ALU unchanged, and the ALU result is returned as-is.

## Test plan
- req0: a=0x7FFFFFFF, b=1, op=0x20, rsp_ready=1 → rsp_valid at T+2, rsp_id=0, rsp_c=0x80000000, rsp_over=1.
- req0 and req1 both held valid (req0 op 0x21, a=1, b=2; req1 op 0x23, a=5, b=3) → grant order 0,1,0,1 with rsp_c alternating 3,2. Neither ready is high while busy=1.
- req1: op=0x03, a=4, b=0xF0000000; rsp_ready held 0 for 5 cycles → rsp_valid and rsp_c=0xFF000000 stable all 5 cycles. No new accept until the rsp handshake.
- rst_n pulsed low during EXEC of op 0x24 → rsp_valid never asserts. After release, busy=0 and req0 wins the next tie.
- With ALU_ARB_ILLEGAL_OP_CHECK_EN: op=0x3F, a=b=0xFFFFFFFF → alu_op=0x00 in EXEC. Response has rsp_err=1, rsp_c=0, rsp_over=0.
